// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit signed/unsigned restoring divider (MIPS DIV/DIVU style).
// Produces quotient on lo and remainder on hi; results change only on done.
module div_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    hi_q, hi_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // The bit shifted out of rem is kept so a partial remainder >= 2^32
  // never registers a false borrow against a large unsigned divisor.
  logic [W:0]      rem_sh;
  logic [W-1:0]    diff;
  logic            borrow;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh[W-1:0] - dvs_q;
    borrow = !rem_sh[W] && (rem_sh[W-1:0] < dvs_q);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sign_d  = sign;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        quo_d  = (sign_q && a_q[W-1]) ? W'(-a_q) : a_q;
        dvs_d  = (sign_q && b_q[W-1]) ? W'(-b_q) : b_q;
        rem_d  = '0;
        cnt_d  = '0;
        qneg_d = sign_q & (a_q[W-1] ^ b_q[W-1]);
        rneg_d = sign_q & a_q[W-1];
        if (b_q == '0) begin
          lo_d    = '1;
          hi_d    = a_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = borrow ? rem_sh[W-1:0] : diff;
        quo_d = {quo_q[W-2:0], !borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = qneg_q ? W'(-quo_q) : quo_q;
        hi_d    = rneg_q ? W'(-rem_q) : rem_q;
        dz_d    = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table, scoreboard queue of
// expected results, and hand sequences for ignore/back-to-back/reset cases.
module tb_div_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        div_zero;

  div_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .lo       (lo),
    .hi       (hi),
    .div_zero (div_zero)
  );

  typedef struct {
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] prev_lo = '0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Independent reference using 64-bit arithmetic
  function automatic vec_t model(input logic sg, input logic [31:0] x, input logic [31:0] y);
    vec_t   v;
    longint sx, sy, q, r;
    v.sign = sg; v.a = x; v.b = y;
    if (y == 32'd0) begin
      v.lo = 32'hFFFFFFFF; v.hi = x; v.dz = 1'b1; v.lat = 2;
    end else begin
      if (sg) begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
      end else begin
        sx = longint'({32'd0, x}); sy = longint'({32'd0, y});
      end
      q = sx / sy;
      r = sx % sy;
      v.lo = q[31:0]; v.hi = r[31:0]; v.dz = 1'b0; v.lat = 35;
    end
    return v;
  endfunction

  // Called #1 after the acceptance edge (cycle 1); returns in the done cycle.
  task automatic wait_done(input string nm);
    int   cyc;
    exp_t e;
    cyc = 1;
    chk({nm, " busy_c1"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 20) chk({nm, " lo_hidden"}, lo, prev_lo);
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL %s: scoreboard empty at done, got none, expected one entry", nm);
      return;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      tests++; failed++;
      $display("FAIL %s timeout: got no done after %0d cycles, expected %0d", nm, cyc, e.lat);
      return;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(e.lat));
    chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, " lo"}, lo, e.lo);
    chk({nm, " hi"}, hi, e.hi);
    chk({nm, " div_zero"}, 32'(div_zero), 32'(e.dz));
    prev_lo = e.lo;
  endtask

  task automatic launch(input vec_t v);
    exp_t e;
    start = 1'b1; sign = v.sign; a = v.a; b = v.b;
    e.lo = v.lo; e.hi = v.hi; e.dz = v.dz; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
  endtask

  initial begin
    vec_t v;
    int   spurious;
    clk = 1'b0; reset_n = 1'b0; start = 1'b1; sign = 1'b0; a = 32'd3; b = 32'd1;

    // Reset with start asserted: start must be discarded
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst div_zero", 32'(div_zero), 32'd0);
    reset_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst start_discarded", 32'(busy), 32'd0);

    tbl.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35});
    tbl.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 35});
    tbl.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 35});
    tbl.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 35});
    tbl.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 2});
    tbl.push_back('{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 35});
    tbl.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 35});
    tbl.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0, 35});
    tbl.push_back('{1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   1'b1, 2});
    tbl.push_back('{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0, 35});
    for (int i = 0; i < 6; i++)
      tbl.push_back(model(i[0], $urandom, $urandom >> $urandom_range(0, 28)));

    foreach (tbl[i]) begin
      launch(tbl[i]);
      wait_done($sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
    end

    // Start during busy ignored; start held through done gives back-to-back
    begin
      int   cyc;
      exp_t e;
      launch('{1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 35});
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
        if (cyc == 10) begin start = 1'b1; a = 32'd1; b = 32'd1; end
        if (cyc == 11) begin start = 1'b0; a = '0; b = '0; end
        if (cyc == 34) begin
          start = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
          e.lo = 32'd14; e.hi = 32'd2; e.dz = 1'b0; e.lat = 35;
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk("ign latency", 32'(cyc), 32'd35);
      if (sb.size() != 0) begin
        void'(sb.pop_front());
      end
      chk("ign lo", lo, 32'd10);
      chk("ign hi", hi, 32'd0);
      prev_lo = 32'd10;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0;
      wait_done("b2b");
    end
    @(posedge clk); #1;

    // Reset in cycle 12 of a divide aborts it with no residue
    start = 1'b1; sign = 1'b0; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort div_zero", 32'(div_zero), 32'd0);
    prev_lo = '0;
    spurious = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    chk("abort no_done", 32'(spurious), 32'd0);
    v = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35};
    launch(v);
    wait_done("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
